// File: rtl/pkt_tx_traffic_gen.sv
// Packet traffic generator for the MAC pkt_tx_* interface: length sweep, inter-packet gap,
// count/continuous modes, back-pressure on pkt_tx_full and a sequence-based checkable payload.
module pkt_tx_traffic_gen #(
    parameter int DATA_W = 64,
    parameter int LEN_W  = 14,
    parameter int IPG_W  = 8,
    parameter int CNT_W  = 32,
    localparam int BYTES = DATA_W / 8,
    localparam int MOD_W = $clog2(BYTES)
) (
    input  logic              clk_156m25,
    input  logic              reset_156m25_n,
    input  logic              start,
    input  logic              stop,
    input  logic [15:0]       cfg_pkt_count,
    input  logic [LEN_W-1:0]  cfg_len_min,
    input  logic [LEN_W-1:0]  cfg_len_max,
    input  logic [IPG_W-1:0]  cfg_ipg,
    input  logic              pkt_tx_full,
    output logic [DATA_W-1:0] pkt_tx_data,
    output logic              pkt_tx_val,
    output logic              pkt_tx_sop,
    output logic              pkt_tx_eop,
    output logic [MOD_W-1:0]  pkt_tx_mod,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  tx_pkt_cnt,
    output logic [CNT_W-1:0]  tx_byte_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_PKT, S_IPG} state_t;

    state_t             state_q, state_d;
    logic [15:0]        cnt_cfg_q, cnt_cfg_d, sent_q, sent_d;
    logic [LEN_W-1:0]   len_min_q, len_min_d, len_max_q, len_max_d;
    logic [LEN_W-1:0]   len_q, len_d, off_q, off_d;
    logic [IPG_W-1:0]   ipg_cfg_q, ipg_cfg_d, ipg_cnt_q, ipg_cnt_d;
    logic [7:0]         seq_q, seq_d;
    logic               stop_pend_q, stop_pend_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               val_q, val_d, sop_q, sop_d, eop_q, eop_d;
    logic [MOD_W-1:0]   mod_q, mod_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d, byte_cnt_q, byte_cnt_d;

    logic [LEN_W-1:0]   lmin_eff, lmax_eff, next_len;
    logic [LEN_W:0]     pos;
    logic [DATA_W-1:0]  beat_data;
    logic               last_beat, count_hit;

    // Byte k of the packet is (seq + k) mod 256; lanes past the packet end read as zero.
    always_comb begin
        beat_data = '0;
        pos       = '0;
        for (int j = 0; j < BYTES; j++) begin
            pos = {1'b0, off_q} + (LEN_W+1)'(j);
            if (pos < {1'b0, len_q})
                beat_data[DATA_W-1-8*j -: 8] = seq_q + off_q[7:0] + 8'(j);
        end
    end

    assign lmin_eff  = (cfg_len_min == '0) ? LEN_W'(1) : cfg_len_min;
    assign lmax_eff  = (cfg_len_max < lmin_eff) ? lmin_eff : cfg_len_max;
    assign next_len  = (len_q >= len_max_q) ? len_min_q : len_q + LEN_W'(1);
    assign last_beat = ({1'b0, off_q} + (LEN_W+1)'(BYTES)) >= {1'b0, len_q};
    assign count_hit = (cnt_cfg_q != '0) && (sent_q + 16'd1 == cnt_cfg_q);

    // NOTE: every _d gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_cfg_d   = cnt_cfg_q;
        sent_d      = sent_q;
        len_min_d   = len_min_q;
        len_max_d   = len_max_q;
        len_d       = len_q;
        off_d       = off_q;
        ipg_cfg_d   = ipg_cfg_q;
        ipg_cnt_d   = ipg_cnt_q;
        seq_d       = seq_q;
        stop_pend_d = stop_pend_q;
        data_d      = '0;
        val_d       = 1'b0;
        sop_d       = 1'b0;
        eop_d       = 1'b0;
        mod_d       = '0;
        done_d      = 1'b0;
        pkt_cnt_d   = pkt_cnt_q;
        byte_cnt_d  = byte_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_cfg_d   = cfg_pkt_count;
                    len_min_d   = lmin_eff;
                    len_max_d   = lmax_eff;
                    len_d       = lmin_eff;
                    ipg_cfg_d   = cfg_ipg;
                    off_d       = '0;
                    seq_d       = '0;
                    sent_d      = '0;
                    stop_pend_d = 1'b0;
                    state_d     = S_PKT;
                end
            end
            S_PKT: begin
                if (stop) stop_pend_d = 1'b1;
                if (!pkt_tx_full) begin
                    val_d  = 1'b1;
                    sop_d  = (off_q == '0);
                    data_d = beat_data;
                    if (last_beat) begin
                        eop_d      = 1'b1;
                        mod_d      = len_q[MOD_W-1:0];
                        pkt_cnt_d  = pkt_cnt_q + CNT_W'(1);
                        byte_cnt_d = byte_cnt_q + CNT_W'(len_q);
                        sent_d     = sent_q + 16'd1;
                        seq_d      = seq_q + 8'd1;
                        len_d      = next_len;
                        off_d      = '0;
                        if (count_hit || stop_pend_q || stop) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else if (ipg_cfg_q != '0) begin
                            state_d   = S_IPG;
                            ipg_cnt_d = ipg_cfg_q;
                        end
                    end else begin
                        off_d = off_q + LEN_W'(BYTES);
                    end
                end
            end
            S_IPG: begin
                if (stop) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (ipg_cnt_q == IPG_W'(1)) begin
                    state_d = S_PKT;
                end else begin
                    ipg_cnt_d = ipg_cnt_q - IPG_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_156m25) begin
        if (!reset_156m25_n) begin
            state_q     <= S_IDLE;
            cnt_cfg_q   <= '0;
            sent_q      <= '0;
            len_min_q   <= '0;
            len_max_q   <= '0;
            len_q       <= '0;
            off_q       <= '0;
            ipg_cfg_q   <= '0;
            ipg_cnt_q   <= '0;
            seq_q       <= '0;
            stop_pend_q <= 1'b0;
            data_q      <= '0;
            val_q       <= 1'b0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            mod_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pkt_cnt_q   <= '0;
            byte_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_cfg_q   <= cnt_cfg_d;
            sent_q      <= sent_d;
            len_min_q   <= len_min_d;
            len_max_q   <= len_max_d;
            len_q       <= len_d;
            off_q       <= off_d;
            ipg_cfg_q   <= ipg_cfg_d;
            ipg_cnt_q   <= ipg_cnt_d;
            seq_q       <= seq_d;
            stop_pend_q <= stop_pend_d;
            data_q      <= data_d;
            val_q       <= val_d;
            sop_q       <= sop_d;
            eop_q       <= eop_d;
            mod_q       <= mod_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pkt_cnt_q   <= pkt_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
        end
    end

    assign pkt_tx_data = data_q;
    assign pkt_tx_val  = val_q;
    assign pkt_tx_sop  = sop_q;
    assign pkt_tx_eop  = eop_q;
    assign pkt_tx_mod  = mod_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign tx_pkt_cnt  = pkt_cnt_q;
    assign tx_byte_cnt = byte_cnt_q;

endmodule

// File: tb/tb_pkt_tx_traffic_gen.sv
// Bench for pkt_tx_traffic_gen: a packet-level reference model expands each run into expected
// beats, and every clock compares the DUT stream, counters, done and busy against it.
module tb_pkt_tx_traffic_gen;

    localparam int DW = 64;
    localparam int BY = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, stop, pkt_tx_full;
    logic [15:0]   cfg_pkt_count;
    logic [13:0]   cfg_len_min, cfg_len_max;
    logic [7:0]    cfg_ipg;
    logic [DW-1:0] pkt_tx_data;
    logic          pkt_tx_val, pkt_tx_sop, pkt_tx_eop;
    logic [2:0]    pkt_tx_mod;
    logic          busy, done;
    logic [31:0]   tx_pkt_cnt, tx_byte_cnt;

    pkt_tx_traffic_gen dut (
        .clk_156m25     (clk),
        .reset_156m25_n (rst_n),
        .start          (start),
        .stop           (stop),
        .cfg_pkt_count  (cfg_pkt_count),
        .cfg_len_min    (cfg_len_min),
        .cfg_len_max    (cfg_len_max),
        .cfg_ipg        (cfg_ipg),
        .pkt_tx_full    (pkt_tx_full),
        .pkt_tx_data    (pkt_tx_data),
        .pkt_tx_val     (pkt_tx_val),
        .pkt_tx_sop     (pkt_tx_sop),
        .pkt_tx_eop     (pkt_tx_eop),
        .pkt_tx_mod     (pkt_tx_mod),
        .busy           (busy),
        .done           (done),
        .tx_pkt_cnt     (tx_pkt_cnt),
        .tx_byte_cnt    (tx_byte_cnt)
    );

    always #3 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [2:0]    mod;
        int            len;
        bit            last;
    } beat_t;

    beat_t         exp_q[$];
    logic [DW-1:0] eop_data[$];
    int            eop_mod[$];
    int            n_cmp = 0, n_fail = 0;
    int            cyc = 0, m_pkts = 0, m_bytes = 0;
    int            n_beats = 0, n_sops = 0, gap_exp = -1, last_eop_cyc = -1;
    bit            exp_busy = 0, force_done = 0;
    logic [DW-1:0] last_sop_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One packet of sequence s and length len, split into BY-byte beats, byte k = (s + k) mod 256.
    task automatic push_pkt(input int s, input int len, input bit last);
        int    nb;
        beat_t b;
        nb = (len + BY - 1) / BY;
        for (int i = 0; i < nb; i++) begin
            b.data = '0;
            for (int j = 0; j < BY; j++)
                if (i * BY + j < len) b.data[DW-1-8*j -: 8] = 8'((s + i * BY + j) % 256);
            b.sop  = (i == 0);
            b.eop  = (i == nb - 1);
            b.mod  = b.eop ? 3'(len % BY) : 3'd0;
            b.len  = len;
            b.last = last && b.eop;
            exp_q.push_back(b);
        end
    endtask

    task automatic tick();
        logic  f, st, r;
        bit    exp_done;
        beat_t e;
        f = pkt_tx_full; st = start; r = rst_n;
        @(posedge clk); #1;
        cyc++;
        exp_done   = force_done;
        force_done = 0;
        if (st && r && !exp_busy) exp_busy = 1;
        if (f) chk("val_while_full", pkt_tx_val, 1'b0);
        if (pkt_tx_val && !f) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", pkt_tx_val, 1'b0);
            end else begin
                e = exp_q.pop_front();
                n_beats++;
                chk("data", pkt_tx_data, e.data);
                chk("sop", pkt_tx_sop, e.sop);
                chk("eop", pkt_tx_eop, e.eop);
                chk("mod", pkt_tx_mod, e.mod);
                if (e.sop) begin
                    n_sops++;
                    last_sop_data = pkt_tx_data;
                    if (gap_exp >= 0 && last_eop_cyc >= 0)
                        chk("ipg_gap", cyc - last_eop_cyc - 1, gap_exp);
                end
                if (e.eop) begin
                    m_pkts++;
                    m_bytes += e.len;
                    chk("tx_pkt_cnt", tx_pkt_cnt, 32'(m_pkts));
                    chk("tx_byte_cnt", tx_byte_cnt, 32'(m_bytes));
                    eop_data.push_back(pkt_tx_data);
                    eop_mod.push_back(int'(pkt_tx_mod));
                    last_eop_cyc = cyc;
                    if (e.last) exp_done = 1;
                end
            end
        end
        if (!pkt_tx_val) chk("idle_flags", {pkt_tx_sop, pkt_tx_eop, pkt_tx_mod}, 5'd0);
        chk("done", done, exp_done);
        if (exp_done) exp_busy = 0;
        chk("busy", busy, exp_busy);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        pkt_tx_full = 1'b0;
        exp_q.delete();
        exp_busy = 0;
        m_pkts = 0;
        m_bytes = 0;
        tick();
        chk("rst_data", pkt_tx_data, '0);
        chk("rst_val", pkt_tx_val, 1'b0);
        chk("rst_pkt_cnt", tx_pkt_cnt, '0);
        chk("rst_byte_cnt", tx_byte_cnt, '0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle", pkt_tx_val, 1'b0);
    endtask

    // Apply config, expand npk packets into the model (sweep wraps min..max), pulse start.
    task automatic start_run(input int lmin, input int lmax, input int cnt, input int ipg,
                             input int npk, input bit last_final, input bit with_stop);
        int le, he, len;
        le  = (lmin < 1) ? 1 : lmin;
        he  = (lmax < le) ? le : lmax;
        len = le;
        for (int s = 0; s < npk; s++) begin
            push_pkt(s, len, last_final && (s == npk - 1));
            len = (len >= he) ? le : len + 1;
        end
        cfg_len_min   = 14'(lmin);
        cfg_len_max   = 14'(lmax);
        cfg_pkt_count = 16'(cnt);
        cfg_ipg       = 8'(ipg);
        n_beats = 0;
        n_sops = 0;
        last_eop_cyc = -1;
        eop_data.delete();
        eop_mod.delete();
        start = 1'b1;
        stop  = with_stop;
        tick();
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic run_until_idle(input int budget, input int full_pct);
        int n = 0;
        while ((exp_busy || exp_q.size() != 0) && n < budget) begin
            pkt_tx_full = ($urandom_range(99) < full_pct);
            tick();
            n++;
        end
        pkt_tx_full = 1'b0;
        chk("timeout_left", exp_q.size(), 0);
    endtask

    initial begin
        cfg_pkt_count = '0; cfg_len_min = '0; cfg_len_max = '0; cfg_ipg = '0;
        do_reset();

        // Two 64-byte packets back to back.
        start_run(64, 64, 2, 0, 2, 1, 0);
        gap_exp = 0;
        run_until_idle(100, 0);
        chk("t1_beats", n_beats, 16);
        chk("t1_eop0", eop_data[0], 64'h38393a3b3c3d3e3f);
        chk("t1_pkts", tx_pkt_cnt, 32'd2);
        chk("t1_bytes", tx_byte_cnt, 32'd128);
        gap_exp = -1;

        // Length sweep 60..62 with wrap.
        do_reset();
        start_run(60, 62, 4, 0, 4, 1, 0);
        run_until_idle(100, 0);
        chk("t2_eop0", eop_data[0], 64'h38393a3b00000000);
        chk("t2_mod0", eop_mod[0], 4);
        chk("t2_mod2", eop_mod[2], 6);
        chk("t2_mod3", eop_mod[3], 4);
        chk("t2_bytes", tx_byte_cnt, 32'd243);

        // Single short packet; stop coincident with start must be ignored.
        do_reset();
        start_run(3, 3, 1, 0, 1, 1, 1);
        run_until_idle(20, 0);
        chk("t3_data", last_sop_data, 64'h0001020000000000);
        chk("t3_mod", eop_mod[0], 3);

        // Five-cycle stall starting at beat 3.
        do_reset();
        start_run(64, 64, 1, 0, 1, 1, 0);
        for (int i = 0; i < 20 && n_beats < 3; i++) tick();
        pkt_tx_full = 1'b1;
        repeat (5) tick();
        pkt_tx_full = 1'b0;
        run_until_idle(40, 0);
        chk("t4_beats", n_beats, 8);

        // Continuous with ipg=4, stop during packet 2.
        do_reset();
        start_run(32, 32, 0, 4, 3, 1, 0);
        gap_exp = 4;
        for (int i = 0; i < 100 && n_sops < 3; i++) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        run_until_idle(40, 0);
        chk("t5_pkts", tx_pkt_cnt, 32'd3);
        chk("t5_busy", busy, 1'b0);
        gap_exp = -1;

        // Stop while in the gap ends the run at once.
        do_reset();
        start_run(8, 8, 0, 10, 1, 0, 0);
        for (int i = 0; i < 20 && m_pkts < 1; i++) tick();
        repeat (2) tick();
        stop = 1'b1;
        force_done = 1;
        tick();
        stop = 1'b0;
        repeat (12) tick();
        chk("t6_pkts", tx_pkt_cnt, 32'd1);

        // Reset mid-packet, then a fresh run starts at sequence 0.
        do_reset();
        start_run(64, 64, 1, 0, 1, 1, 0);
        for (int i = 0; i < 20 && n_beats < 3; i++) tick();
        do_reset();
        start_run(8, 8, 1, 0, 1, 1, 0);
        run_until_idle(20, 0);
        chk("t7_seq0", last_sop_data, 64'h0001020304050607);
        chk("t7_pkts", tx_pkt_cnt, 32'd1);

        // Randomised runs with random back-pressure; counters accumulate across runs.
        for (int r = 0; r < 8; r++) begin
            int lmin, lmax, cnt, ipg;
            lmin = $urandom_range(0, 20);
            lmax = $urandom_range(0, 30);
            cnt  = $urandom_range(1, 5);
            ipg  = $urandom_range(0, 3);
            start_run(lmin, lmax, cnt, ipg, cnt, 1, 0);
            run_until_idle(2000, 30);
            repeat (2) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
